// File: rtl/dff_bist_pkg.sv
// dff_bist_pkg: shared types and constants for the D flip-flop BIST engine.
//   bist_state_e : engine FSM states (idle, issuing vectors, draining, done)
//   LfsrTaps     : Fibonacci tap mask for x^8+x^6+x^5+x^4+1
//   ErrCntW/Max  : error counter width and its saturation value
package dff_bist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } bist_state_e;

  localparam logic [7:0] LfsrTaps = 8'hB8;

  localparam int unsigned ErrCntW = 16;
  localparam logic [ErrCntW-1:0] ErrCntMax = '1;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, right-shifting, feedback into bit 7.
//   clk   : clock
//   rst_n : synchronous active-low reset, reloads seed
//   load  : load seed (has priority over en)
//   seed  : value loaded on reset or load
//   en    : advance one step
//   state : current register contents
module lfsr8
  import dff_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = {^(state_q & LfsrTaps), state_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dff_bist.sv
// dff_bist: built-in self test for a single-bit D flip-flop cell.
// Drives a pseudo-random stream on d and checks q / q_c after LATENCY stages.
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : begin a run (accepted only when idle or done)
//   q, q_c        : true / complementary outputs of the flop under test
//   d             : stimulus bit to the flop under test
//   busy          : run or drain in progress
//   done          : results valid and held
//   pass          : no errors in the last run (valid while done)
//   err_count     : saturating count of failing vectors
//   first_err_idx : index of the first failing vector, all-ones if none
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int unsigned  N_VECTORS = 64,
  parameter int unsigned  LATENCY   = 1,
  parameter logic [7:0]   SEED      = 8'hA5,
  localparam int unsigned CNT_W     = $clog2(N_VECTORS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               q,
  input  logic               q_c,
  output logic               d,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ErrCntW-1:0] err_count,
  output logic [CNT_W-1:0]   first_err_idx
);

  localparam logic [7:0]       SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int unsigned      DrnW    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_VECTORS - 1);
  localparam logic [DrnW-1:0]  LastDrn = DrnW'(LATENCY);

  typedef struct packed {
    logic             valid;
    logic             exp;
    logic [CNT_W-1:0] idx;
  } chk_t;

  bist_state_e         state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [DrnW-1:0]     drn_q, drn_d;
  logic [ErrCntW-1:0]  err_q, err_d;
  logic [CNT_W-1:0]    fidx_q, fidx_d;
  logic                lfsr_load, lfsr_en, clear_res;
  logic [7:0]          lfsr_state;
  logic                unused_lfsr;
  chk_t                iss, chk;
  chk_t [LATENCY-1:0]  pipe_q;
  logic                mismatch;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SeedEff),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[7:1];

  // FSM next state; the LFSR is loaded with the seed on the accepting edge so
  // vector 0 is already on d in the first RUN cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drn_d     = drn_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    clear_res = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          idx_d     = '0;
          lfsr_load = 1'b1;
          clear_res = 1'b1;
        end
      end
      StRun: begin
        lfsr_en = 1'b1;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          drn_d   = '0;
        end
      end
      StDrain: begin
        if (drn_q == LastDrn) begin
          state_d = StDone;
        end else begin
          drn_d = drn_q + DrnW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 0 of the expected-value pipeline is the vector currently on d.
  always_comb begin
    iss.valid = (state_q == StRun);
    iss.exp   = lfsr_state[0];
    iss.idx   = idx_q;
  end

  if (LATENCY == 1) begin : g_pipe1
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= iss;
      end
    end
  end else begin : g_pipen
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= {pipe_q[LATENCY-2:0], iss};
      end
    end
  end

  assign chk      = pipe_q[LATENCY-1];
  assign mismatch = chk.valid & ((q != chk.exp) | (q_c != ~q));

  always_comb begin
    err_d  = err_q;
    fidx_d = fidx_q;
    if (clear_res) begin
      err_d  = '0;
      fidx_d = '1;
    end else if (mismatch) begin
      if (err_q != ErrCntMax) begin
        err_d = err_q + ErrCntW'(1);
      end
      if (err_q == '0) begin
        fidx_d = chk.idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      drn_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  assign d             = (state_q == StRun) & lfsr_state[0];
  assign busy          = (state_q == StRun) | (state_q == StDrain);
  assign done          = (state_q == StDone);
  assign pass          = done & (err_q == '0);
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_dff_bist.sv
// tb_dff_bist: self-checking bench for dff_bist. Five engines run against
// bench-modelled flops: ideal with random error injection (a), q_c tied to q
// (b), 2-stage flop (c), 3-stage flop with SEED=0 (d), long saturating run (e).
module tb_dff_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference stimulus: stream bit k is bit 0 of the seed after k steps of
  // the polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
  endfunction

  function automatic logic vec_bit(input logic [7:0] seed, input int k);
    logic [7:0] s = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < k; i++) s = lfsr_step(s);
    return s[0];
  endfunction

  logic rst_n, rst_a_n;

  // a: ideal 1-stage flop, error injected into the captured value
  logic start_a, inj_a, d_a, busy_a, done_a, pass_a;
  logic fa = 1'b0;
  logic [15:0] err_a;
  logic [4:0]  fidx_a;
  always @(posedge clk) fa <= d_a ^ inj_a;
  dff_bist #(.N_VECTORS(16), .LATENCY(1), .SEED(8'hA5)) u_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .q(fa), .q_c(~fa), .d(d_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(fidx_a)
  );

  // b: correct q, q_c wrongly equal to q
  logic start_b, d_b, busy_b, done_b, pass_b;
  logic fb = 1'b0;
  logic [15:0] err_b;
  logic [4:0]  fidx_b;
  always @(posedge clk) fb <= d_b;
  dff_bist #(.N_VECTORS(16), .LATENCY(1), .SEED(8'hA5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .q(fb), .q_c(fb), .d(d_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fidx_b)
  );

  // c: 2-stage flop checked as if 1-stage
  logic start_c, d_c, busy_c, done_c, pass_c;
  logic c1 = 1'b0, c2 = 1'b0;
  logic [15:0] err_c;
  logic [4:0]  fidx_c;
  always @(posedge clk) begin
    c1 <= d_c;
    c2 <= c1;
  end
  dff_bist #(.N_VECTORS(16), .LATENCY(1), .SEED(8'hA5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .q(c2), .q_c(~c2), .d(d_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(fidx_c)
  );

  // d: 3-stage flop, LATENCY=3, SEED=0 (substituted by 1)
  logic start_d, d_d, busy_d, done_d, pass_d;
  logic e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
  logic [15:0] err_d;
  logic [2:0]  fidx_d;
  always @(posedge clk) begin
    e1 <= d_d;
    e2 <= e1;
    e3 <= e2;
  end
  dff_bist #(.N_VECTORS(5), .LATENCY(3), .SEED(8'h00)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .q(e3), .q_c(~e3), .d(d_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d), .first_err_idx(fidx_d)
  );

  // e: long run, every vector fails, counter must saturate
  logic start_e, d_e, busy_e, done_e, pass_e;
  logic fe = 1'b0;
  logic [15:0] err_e;
  logic [16:0] fidx_e;
  int got_e = 0;
  always @(posedge clk) fe <= d_e;
  dff_bist #(.N_VECTORS(70000), .LATENCY(1), .SEED(8'hA5)) u_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .q(fe), .q_c(fe), .d(d_e),
    .busy(busy_e), .done(done_e), .pass(pass_e), .err_count(err_e), .first_err_idx(fidx_e)
  );

  // mode 0: clean, 1: random injection, 2: inject every vector, reset at S+5
  task automatic run_a(input int mode);
    logic [15:0] flip = '0;
    int got = 0;
    int ne;
    int first;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_eq("a_busy_after_s", busy_a, 1);
    check_eq("a_err_cleared", err_a, 0);
    check_eq("a_fidx_cleared", fidx_a, 5'h1F);
    check_eq("a_done_cleared", done_a, 0);
    for (int c = 0; c < 40 && got == 0; c++) begin
      if (c < 16) begin
        check_eq($sformatf("a_d_vec%0d", c), d_a, vec_bit(8'hA5, c));
        flip[c] = (mode == 1) ? ($urandom_range(3) == 0) : (mode == 2);
        inj_a = flip[c];
      end else begin
        inj_a = 1'b0;
      end
      if (c == 16) check_eq("a_d_zero_drain", d_a, 0);
      start_a = (c == 2);
      if (mode == 2 && c == 4) begin
        check_eq("a_err_before_rst", err_a, 3);
        rst_a_n = 1'b0;
      end
      @(posedge clk); #1;
      if (mode == 2 && c == 4) begin
        check_eq("a_rst_busy", busy_a, 0);
        check_eq("a_rst_d", d_a, 0);
        check_eq("a_rst_err", err_a, 0);
        check_eq("a_rst_done", done_a, 0);
        check_eq("a_rst_fidx", fidx_a, 5'h1F);
        rst_a_n = 1'b1;
        inj_a   = 1'b0;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("a_rst_no_checks", err_a, 0);
        return;
      end
      if (done_a) got = c + 1;
    end
    start_a = 1'b0;
    inj_a   = 1'b0;
    check_eq("a_done_latency", got, 18);
    ne    = $countones(flip);
    first = 31;
    for (int k = 15; k >= 0; k--) if (flip[k]) first = k;
    check_eq("a_err_count", err_a, ne);
    check_eq("a_first_err", fidx_a, first);
    check_eq("a_pass", pass_a, (ne == 0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("a_done_held", done_a, 1);
  endtask

  task automatic run_bcd();
    int got_b = 0, got_c = 0, got_d = 0;
    int ne = 0;
    int first = 31;
    logic prev;
    start_b = 1'b1;
    start_c = 1'b1;
    start_d = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    start_c = 1'b0;
    start_d = 1'b0;
    check_eq("d_first_vec_seed0", d_d, vec_bit(8'h00, 0));
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_b && got_b == 0) got_b = c;
      if (done_c && got_c == 0) got_c = c;
      if (done_d && got_d == 0) got_d = c;
    end
    check_eq("b_done_latency", got_b, 18);
    check_eq("b_err_count", err_b, 16);
    check_eq("b_first_err", fidx_b, 0);
    check_eq("b_pass", pass_b, 0);
    for (int k = 0; k < 16; k++) begin
      prev = (k == 0) ? 1'b0 : vec_bit(8'hA5, k - 1);
      if (vec_bit(8'hA5, k) != prev) begin
        if (ne == 0) first = k;
        ne++;
      end
    end
    check_eq("c_done_latency", got_c, 18);
    check_eq("c_err_count", err_c, ne);
    check_eq("c_first_err", fidx_c, first);
    check_eq("c_pass", pass_c, (ne == 0));
    check_eq("d_done_latency", got_d, 9);
    check_eq("d_err_count", err_d, 0);
    check_eq("d_first_err", fidx_d, 3'h7);
    check_eq("d_pass", pass_d, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_a_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    start_d = 1'b0;
    start_e = 1'b0;
    inj_a   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_pass", pass_a, 0);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_fidx", fidx_a, 5'h1F);
    check_eq("rst_d", d_a, 0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_eq("rst_beats_start", busy_a, 0);
    rst_n   = 1'b1;
    rst_a_n = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        for (int c = 1; c <= 70100 && got_e == 0; c++) begin
          @(posedge clk); #1;
          if (done_e) got_e = c;
        end
      end
      begin
        run_a(1);
        run_a(1);
        run_a(2);
        run_a(0);
        run_bcd();
      end
    join
    check_eq("e_done_latency", got_e, 70002);
    check_eq("e_err_saturated", err_e, 16'hFFFF);
    check_eq("e_first_err", fidx_e, 0);
    check_eq("e_pass", pass_e, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
